dmem_line_responder: RTL and testbench

// - Data-memory side of the 256-bit line interface driven by dcache_top (mem_enable/mem_write/mem_addr/mem_data/mem_ack).
// - Accepts one line read or line write per request and answers after a fixed, parameterised latency with a 1-cycle ack.
// - Backs the data cache in the CPU top level; it is the only responder on that interface.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_line_array.sv | 37 +++
 rtl/dmem_line_responder.sv | 174 +++++++++++++++++
 tb/tb_dmem_line_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared constants and types for the data-memory line responder.
//   LINE_W    : width of one cache line (bits)
//   OFFSET_W  : byte-offset bits inside a line (ignored by the responder)
//   ADDR_W    : byte-address width on the line interface
//   IDLE/BUSY/ACK : FSM state encodings, wrapped by the dmem_state_e enum
// ---------------------------------------------------------------------------
package dmem_pkg;

  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;
  localparam int ADDR_W   = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_BUSY = BUSY,
    ST_ACK  = ACK
  } dmem_state_e;

endpackage : dmem_pkg

// File: rtl/dmem_line_array.sv
// ---------------------------------------------------------------------------
// dmem_line_array
// Single-port synchronous line store, DEPTH x LINE_W, with a registered read
// port (read-before-write on the shared port). Contents are never reset.
// Ports:
//   clk_i    in   clock
//   we_i     in   write enable for this edge
//   addr_i   in   line index (shared by read and write)
//   wdata_i  in   line to write
//   rdata_o  out  line at addr_i, registered at the previous edge
// ---------------------------------------------------------------------------
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_q [DEPTH];
  logic [LINE_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule : dmem_line_array

// File: rtl/dmem_line_responder.sv
// ---------------------------------------------------------------------------
// dmem_line_responder
// Data-memory responder for the data cache's 256-bit line interface. Each
// request (line read or line write) is committed at the edge where it is
// sampled in IDLE and answered exactly LATENCY cycles later with a one-cycle
// ack_o. Read data is held on data_o until the next read completes.
//
// Optional feature macro: DMEM_REQ_CHECK_EN
//   When defined, err_o is added: a sticky flag raised whenever the requester
//   drops enable_i or changes addr_i[31:5] / write_i while a request is BUSY.
//
// Ports:
//   clk_i     in   clock
//   rst_i     in   asynchronous active-low reset
//   enable_i  in   request valid
//   write_i   in   1 = line write, 0 = line read
//   addr_i    in   byte address; line index = addr_i[IDX_W+4:5]
//   data_i    in   write line data
//   ack_o     out  one-cycle completion pulse
//   data_o    out  last read line
//   err_o     out  protocol-violation flag (DMEM_REQ_CHECK_EN only)
// ---------------------------------------------------------------------------
module dmem_line_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY    = 10,
  parameter int LINE_DEPTH = 512
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
`ifdef DMEM_REQ_CHECK_EN
  ,
  output logic              err_o
`endif
);

  localparam int IDX_W = $clog2(LINE_DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              write_q, write_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] data_q, data_d;

  logic              arr_we;
  logic [IDX_W-1:0]  arr_addr;
  logic [LINE_W-1:0] arr_rdata;
  logic [IDX_W-1:0]  req_idx;

  // Offset bits and aliased upper bits are intentionally don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_i;

  assign req_idx = addr_i[IDX_W+OFFSET_W-1:OFFSET_W];

  // In IDLE the array is addressed straight from the bus so the read is
  // already registered at the sample edge; this is what lets LATENCY=1 return
  // valid data. Afterwards the latched index keeps the address stable.
  assign arr_addr = (state_q == ST_IDLE) ? req_idx : idx_q;

  dmem_line_array #(
    .DEPTH (LINE_DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (arr_we),
    .addr_i  (arr_addr),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
    end
  end

  // With LATENCY=1 the counter is loaded with 0, so the request spends a
  // single cycle waiting and the ack still rises at T0+1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    arr_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_d = ST_BUSY;
          cnt_d   = LAT_M1;
          idx_d   = req_idx;
          write_d = write_i;
          wdata_d = data_i;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_ACK;
          if (write_q) begin
            arr_we = 1'b1;
          end else begin
            data_d = arr_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ack_o  = (state_q == ST_ACK);
  assign data_o = data_q;

`ifdef DMEM_REQ_CHECK_EN
  logic [ADDR_W-OFFSET_W-1:0] addr_hi_q, addr_hi_d;
  logic                       err_q, err_d;
  logic                       hold_broken;

  assign hold_broken = (state_q == ST_BUSY) &&
                       (!enable_i ||
                        (addr_i[ADDR_W-1:OFFSET_W] != addr_hi_q) ||
                        (write_i != write_q));

  always_comb begin
    addr_hi_d = addr_hi_q;
    err_d     = err_q | hold_broken;
    if ((state_q == ST_IDLE) && enable_i) begin
      addr_hi_d = addr_i[ADDR_W-1:OFFSET_W];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      addr_hi_q <= '0;
      err_q     <= 1'b0;
    end else begin
      addr_hi_q <= addr_hi_d;
      err_q     <= err_d;
    end
  end

  assign err_o = err_q;
`endif

endmodule : dmem_line_responder

// File: tb/tb_dmem_line_responder.sv
module tb_dmem_line_responder;

  logic         clk;
  logic         rst_n;
  logic         en0, wr0, ack0;
  logic [31:0]  addr0;
  logic [255:0] din0, dout0;
  logic         en1, wr1, ack1;
  logic [31:0]  addr1;
  logic [255:0] din1, dout1;
`ifdef DMEM_REQ_CHECK_EN
  logic         err0, err1;
`endif

  int vectors;
  int miscompares;

  localparam logic [255:0] PAT_55 = {32{8'h55}};
  localparam logic [255:0] PAT_AA = {32{8'hAA}};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_line_responder #(.LATENCY(10), .LINE_DEPTH(512)) u0 (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .enable_i (en0),
    .write_i  (wr0),
    .addr_i   (addr0),
    .data_i   (din0),
    .ack_o    (ack0),
    .data_o   (dout0)
`ifdef DMEM_REQ_CHECK_EN
    ,
    .err_o    (err0)
`endif
  );

  dmem_line_responder #(.LATENCY(1), .LINE_DEPTH(512)) u1 (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .enable_i (en1),
    .write_i  (wr1),
    .addr_i   (addr1),
    .data_i   (din1),
    .ack_o    (ack1),
    .data_o   (dout1)
`ifdef DMEM_REQ_CHECK_EN
    ,
    .err_o    (err1)
`endif
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic en, input logic wr,
                       input logic [31:0] a, input logic [255:0] d);
    if (sel == 0) begin
      en0 = en; wr0 = wr; addr0 = a; din0 = d;
    end else begin
      en1 = en; wr1 = wr; addr1 = a; din1 = d;
    end
  endtask

  function automatic logic get_ack(input int sel);
    return (sel == 0) ? ack0 : ack1;
  endfunction

  function automatic logic [255:0] get_dout(input int sel);
    return (sel == 0) ? dout0 : dout1;
  endfunction

  // One committed transaction; inputs are scrambled right after the sample
  // edge to show the request is latched. exp_dout is data_o at ack and after.
  task automatic txn(input int sel, input logic wr, input logic [31:0] a,
                     input logic [255:0] d, input logic [255:0] exp_dout, input string tag);
    int lat;
    int first;
    int nack;
    logic [255:0] at_ack;
    lat    = (sel == 0) ? 10 : 1;
    first  = 0;
    nack   = 0;
    at_ack = 'x;
    @(negedge clk);
    drive(sel, 1'b1, wr, a, d);
    @(posedge clk);
    for (int k = 1; k <= lat + 6; k++) begin
      @(negedge clk);
      if (k == 1) drive(sel, 1'b0, ~wr, ~a, ~d);
      if (get_ack(sel)) begin
        nack++;
        if (first == 0) begin
          first  = k;
          at_ack = get_dout(sel);
        end
      end
    end
    chk({tag, " ack_cycle"}, 256'(first), 256'(lat + 1));
    chk({tag, " ack_count"}, 256'(nack), 256'd1);
    chk({tag, " data_at_ack"}, at_ack, exp_dout);
    chk({tag, " data_hold"}, get_dout(sel), exp_dout);
  endtask

  initial begin
    int nack;
    int first;
    int second;
    logic [255:0] at_ack;
    logic [5:0]   pattern;

    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, '0);
    drive(1, 1'b0, 1'b0, 32'h0, '0);
    repeat (3) @(negedge clk);
    chk("reset ack0", 256'(ack0), 256'd0);
    chk("reset dout0", dout0, '0);
    chk("reset ack1", 256'(ack1), 256'd0);
    chk("reset dout1", dout1, '0);
    rst_n = 1'b1;

    // Read latency on line 5, write-then-read on line 32 and its alias.
    txn(0, 1'b1, 32'h0000_00A0, 256'h1234, '0, "wr line5");
    txn(0, 1'b0, 32'h0000_00A0, '0, 256'h1234, "rd line5");
    txn(0, 1'b1, 32'h0000_0400, 256'hDEADBEEF, 256'h1234, "wr line32");
    txn(0, 1'b0, 32'h0000_041F, '0, 256'hDEADBEEF, "rd line32");
    txn(0, 1'b0, 32'h0000_4400, '0, 256'hDEADBEEF, "rd alias32");

    // Reset aborts a pending write to line 3.
    txn(0, 1'b1, 32'h0000_0060, PAT_55, 256'hDEADBEEF, "wr line3");
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h0000_0060, PAT_AA);
    @(posedge clk);
    nack = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) drive(0, 1'b0, 1'b0, 32'h0, '0);
      if (ack0) nack++;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst ack0", 256'(ack0), 256'd0);
    chk("midrst dout0", dout0, '0);
    rst_n = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (ack0) nack++;
    end
    chk("midrst no_ack", 256'(nack), 256'd0);
    txn(0, 1'b0, 32'h0000_0060, '0, PAT_55, "rd line3");

    // Back-to-back with enable held: write line 7, switch to read line 9.
    txn(0, 1'b1, 32'h0000_0120, 256'hC0FFEE, PAT_55, "wr line9");
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h0000_00E0, 256'h77);
    @(posedge clk);
    nack = 0; first = 0; second = 0; at_ack = 'x;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      if (ack0) begin
        nack++;
        if (first == 0) first = k;
        else if (second == 0) begin
          second = k;
          at_ack = dout0;
        end
      end
      if (k == 11) drive(0, 1'b1, 1'b0, 32'h0000_0120, '0);
      if (k == 13) drive(0, 1'b0, 1'b0, 32'h0, '0);
    end
    chk("b2b first_ack", 256'(first), 256'd11);
    chk("b2b second_ack", 256'(second), 256'd23);
    chk("b2b ack_count", 256'(nack), 256'd2);
    chk("b2b rd line9", at_ack, 256'hC0FFEE);
    txn(0, 1'b0, 32'h0000_00E0, '0, 256'h77, "rd line7");

    // LATENCY=1 instance.
    txn(1, 1'b1, 32'h0000_0020, 256'hABCD, '0, "L1 wr line1");
    txn(1, 1'b0, 32'h0000_0020, '0, 256'hABCD, "L1 rd line1");
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'h0000_0020, '0);
    @(posedge clk);
    pattern = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      pattern[k-1] = ack1;
    end
    drive(1, 1'b0, 1'b0, 32'h0, '0);
    chk("L1 held ack_pattern", 256'(pattern), 256'(6'b010010));
    chk("L1 held dout", dout1, 256'hABCD);

`ifdef DMEM_REQ_CHECK_EN
    // Hold-protocol checker: address moves from 0x20 to 0x40 mid-BUSY.
    txn(0, 1'b1, 32'h0000_0020, 256'h1111, 256'h77, "chk wr line1");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("chk err_reset", 256'(err0), 256'd0);
    drive(0, 1'b1, 1'b0, 32'h0000_0020, '0);
    @(posedge clk);
    first = 0; at_ack = 'x;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 3) drive(0, 1'b1, 1'b0, 32'h0000_0040, '0);
      if (k == 11) drive(0, 1'b0, 1'b0, 32'h0, '0);
      if (ack0 && first == 0) begin
        first  = k;
        at_ack = dout0;
      end
    end
    chk("chk ack_cycle", 256'(first), 256'd11);
    chk("chk rd line1", at_ack, 256'h1111);
    chk("chk err_sticky", 256'(err0), 256'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule : tb_dmem_line_responder
